// File: rtl/i2c_av_cmd_arbiter.sv
// Round-robin arbiter that shares one Altera_UP_I2C controller between the
// auto-init ROM sequencer (port 0) and the runtime host (port 1), with NACK retry.
module i2c_av_cmd_arbiter #(
  parameter int MAX_RETRIES = 3,
  parameter int GAP_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_0,
  input  logic        req_1,
  input  logic [23:0] cmd_0,
  input  logic [23:0] cmd_1,
  output logic        gnt_0,
  output logic        gnt_1,
  output logic        done_0,
  output logic        done_1,
  output logic        err_0,
  output logic        err_1,
  output logic        i2c_send_start_bit,
  output logic        i2c_transfer_data,
  output logic        i2c_send_stop_bit,
  output logic [7:0]  i2c_data_out,
  output logic [2:0]  i2c_num_bits,
  input  logic        i2c_transfer_complete,
  input  logic        i2c_ack,
  output logic        busy
);

  localparam int GAP_W = (GAP_CYCLES  > 0) ? $clog2(GAP_CYCLES + 1)  : 1;
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_START_W,
    S_BYTE,
    S_BYTE_W,
    S_STOP,
    S_STOP_W,
    S_GAP
  } state_e;

  state_e             state_q;
  logic               last_q;
  logic               port_q;
  logic [23:0]        cmd_q;
  logic [1:0]         idx_q;
  logic [RTY_W-1:0]   retry_q;
  logic               nack_q;
  logic               retry_pend_q;
  logic [GAP_W-1:0]   gap_q;
  logic               gnt_0_q, gnt_1_q;
  logic               done_0_q, done_1_q;
  logic               err_0_q, err_1_q;
  logic               start_q, xfer_q, stop_q;
  logic [7:0]         data_q;
  logic               busy_q;
  logic               sel_d;

  // Port 1 wins when it is the only requester, or on a tie after port 0 was served.
  assign sel_d = req_1 & (~req_0 | ~last_q);

  function automatic logic [7:0] byte_sel(input logic [23:0] cmd, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = cmd[23:16];
      2'd1:    b = cmd[15:8];
      default: b = cmd[7:0];
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      port_q       <= 1'b0;
      idx_q        <= 2'd0;
      retry_q      <= '0;
      nack_q       <= 1'b0;
      retry_pend_q <= 1'b0;
      gap_q        <= '0;
      gnt_0_q      <= 1'b0;
      gnt_1_q      <= 1'b0;
      done_0_q     <= 1'b0;
      done_1_q     <= 1'b0;
      err_0_q      <= 1'b0;
      err_1_q      <= 1'b0;
      start_q      <= 1'b0;
      xfer_q       <= 1'b0;
      stop_q       <= 1'b0;
      data_q       <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      gnt_0_q  <= 1'b0;
      gnt_1_q  <= 1'b0;
      done_0_q <= 1'b0;
      done_1_q <= 1'b0;
      err_0_q  <= 1'b0;
      err_1_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req_0 || req_1) begin
            port_q       <= sel_d;
            last_q       <= sel_d;
            cmd_q        <= sel_d ? cmd_1 : cmd_0;
            gnt_0_q      <= ~sel_d;
            gnt_1_q      <= sel_d;
            retry_q      <= '0;
            nack_q       <= 1'b0;
            retry_pend_q <= 1'b0;
            idx_q        <= 2'd0;
            start_q      <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_START;
          end
        end

        S_START: begin
          if (i2c_transfer_complete) begin
            start_q <= 1'b0;
            state_q <= S_START_W;
          end
        end

        S_START_W: begin
          if (!i2c_transfer_complete) begin
            data_q  <= byte_sel(cmd_q, idx_q);
            xfer_q  <= 1'b1;
            state_q <= S_BYTE;
          end
        end

        S_BYTE: begin
          if (i2c_transfer_complete) begin
            xfer_q <= 1'b0;
            if (i2c_ack) nack_q <= 1'b1;
            state_q <= S_BYTE_W;
          end
        end

        S_BYTE_W: begin
          if (!i2c_transfer_complete) begin
            if (nack_q || idx_q == 2'd2) begin
              stop_q  <= 1'b1;
              state_q <= S_STOP;
            end else begin
              idx_q   <= idx_q + 2'd1;
              data_q  <= byte_sel(cmd_q, idx_q + 2'd1);
              xfer_q  <= 1'b1;
              state_q <= S_BYTE;
            end
          end
        end

        S_STOP: begin
          if (i2c_transfer_complete) begin
            stop_q  <= 1'b0;
            idx_q   <= 2'd0;
            state_q <= S_STOP_W;
            if (!nack_q) begin
              done_0_q <= ~port_q;
              done_1_q <= port_q;
            end else if (retry_q < RTY_W'(MAX_RETRIES)) begin
              retry_q      <= retry_q + RTY_W'(1);
              nack_q       <= 1'b0;
              retry_pend_q <= 1'b1;
            end else begin
              done_0_q <= ~port_q;
              done_1_q <= port_q;
              err_0_q  <= ~port_q;
              err_1_q  <= port_q;
            end
          end
        end

        S_STOP_W: begin
          if (!i2c_transfer_complete) begin
            if (GAP_CYCLES > 0) begin
              gap_q   <= GAP_W'(GAP_CYCLES);
              state_q <= S_GAP;
            end else if (retry_pend_q) begin
              retry_pend_q <= 1'b0;
              start_q      <= 1'b1;
              state_q      <= S_START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end

        S_GAP: begin
          // Requests arriving here stay pending until IDLE; a retry skips arbitration.
          if (gap_q == '0) begin
            if (retry_pend_q) begin
              retry_pend_q <= 1'b0;
              start_q      <= 1'b1;
              state_q      <= S_START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_0              = gnt_0_q;
  assign gnt_1              = gnt_1_q;
  assign done_0             = done_0_q;
  assign done_1             = done_1_q;
  assign err_0              = err_0_q;
  assign err_1              = err_1_q;
  assign i2c_send_start_bit = start_q;
  assign i2c_transfer_data  = xfer_q;
  assign i2c_send_stop_bit  = stop_q;
  assign i2c_data_out       = data_q;
  assign i2c_num_bits       = 3'h7;
  assign busy               = busy_q;

endmodule
